// File: rtl/sdram_fetch_pkg.sv
// sdram_fetch_pkg: shared widths, sample types and state encoding for the SDRAM sample fetcher.
package sdram_fetch_pkg;
   localparam int DEF_ADDR_W = 26;
   localparam int DEF_DATA_W = 16;
   typedef logic [DEF_ADDR_W-1:0] addr_t;
   typedef logic [DEF_DATA_W-1:0] sample_t;
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_ISSUE     = 3'd1;
   localparam state_t ST_WAIT_DONE = 3'd2;
   localparam state_t ST_CAPTURE   = 3'd3;
   localparam state_t ST_RELEASE   = 3'd4;
endpackage

// File: rtl/sdram_sample_fetcher_fifo.sv
// sample_fifo: power-of-two sample buffer with wrap-bit pointers; head reads 0 while empty.
module sample_fifo
   import sdram_fetch_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = 8,
   localparam int AW = $clog2(FIFO_DEPTH)
)(
   input  logic              clock_12,
   input  logic              reset_12_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [AW:0]       count_o
);
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0] rd_q, rd_d, wr_q, wr_d;
   logic do_push;
   assign empty_o = rd_q == wr_q;
   assign full_o  = (rd_q[AW] != wr_q[AW]) && (rd_q[AW-1:0] == wr_q[AW-1:0]);
   assign count_o = wr_q - rd_q;
   assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
   assign do_push = push_i && !full_o;
   always_comb begin
      wr_d = flush_i ? '0 : wr_q + {{AW{1'b0}}, do_push};
      rd_d = flush_i ? '0 : rd_q + {{AW{1'b0}}, pop_i && !empty_o};
   end
   always_ff @(posedge clock_12 or negedge reset_12_n) begin
      if (!reset_12_n) begin
         rd_q <= '0;
         wr_q <= '0;
      end else begin
         rd_q <= rd_d;
         wr_q <= wr_d;
      end
   end
   always_ff @(posedge clock_12) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
   end
endmodule

// File: rtl/sdram_sample_fetcher.sv
// sdram_sample_fetcher: walks an SDRAM word range one read at a time and streams the samples.
// Define SDRAM_SAMPLE_FETCHER_LOOP_EN to add loop_en, which replays the range until stop.
module sdram_sample_fetcher
   import sdram_fetch_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = 8
)(
   input  logic              clock_12,
   input  logic              reset_12_n,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
`ifdef SDRAM_SAMPLE_FETCHER_LOOP_EN
   input  logic              loop_en,
`endif
   output logic              busy,
   output logic [ADDR_W-1:0] address_12,
   output logic              request_12,
   input  logic              done_12,
   input  logic [DATA_W-1:0] readdata_12,
   output logic [DATA_W-1:0] sample_data,
   output logic              sample_valid,
   input  logic              sample_ready
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d, rem_q, rem_d, addr_q, addr_d, rl_base, rl_len;
   logic req_q, req_d, busy_q, busy_d, abort_q, abort_d;
   logic push, flush, fifo_full, fifo_empty, can_issue, rl_en, reload;
   logic [CW-1:0] fifo_count;
   assign busy         = busy_q;
   assign address_12   = addr_q;
   assign request_12   = req_q;
   assign sample_valid = !fifo_empty;
   assign can_issue    = int'(fifo_count) < FIFO_DEPTH;
   assign reload       = rl_en && (rem_q == ADDR_W'(1));
   sample_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clock_12  (clock_12),
      .reset_12_n(reset_12_n),
      .push_i    (push),
      .pop_i     (sample_valid && sample_ready),
      .flush_i   (flush),
      .data_i    (readdata_12),
      .data_o    (sample_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );
`ifdef SDRAM_SAMPLE_FETCHER_LOOP_EN
   logic loop_q;
   logic [ADDR_W-1:0] base_q, len_q;
   always_ff @(posedge clock_12 or negedge reset_12_n) begin
      if (!reset_12_n) begin
         loop_q <= 1'b0;
         base_q <= '0;
         len_q  <= '0;
      end else if (state_q == ST_IDLE && start && !stop && !busy_q) begin
         loop_q <= loop_en;
         base_q <= base_addr;
         len_q  <= length;
      end
   end
   assign rl_en   = loop_q;
   assign rl_base = base_q;
   assign rl_len  = len_q;
`else
   assign rl_en   = 1'b0;
   assign rl_base = '0;
   assign rl_len  = '0;
`endif
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      req_d   = req_q;
      busy_d  = busy_q;
      abort_d = abort_q;
      push    = 1'b0;
      flush   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            flush  = stop;
            // busy_q high here is the one-cycle pulse of an empty run, so start is ignored
            if (start && !stop && !busy_q) begin
               busy_d = 1'b1;
               if (length != '0) begin
                  cur_d   = base_addr;
                  rem_d   = length;
                  addr_d  = base_addr;
                  req_d   = can_issue;
                  state_d = can_issue ? ST_WAIT_DONE : ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (stop || rem_q == '0) begin
               flush   = stop;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (can_issue) begin
               addr_d  = cur_q;
               req_d   = 1'b1;
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            abort_d = abort_q || stop;
            if (done_12) begin
               req_d   = 1'b0;
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            abort_d = abort_q || stop;
            state_d = ST_RELEASE;
            if (!abort_d) begin
               push  = !fifo_full;
               cur_d = reload ? rl_base : cur_q + ADDR_W'(1);
               rem_d = reload ? rl_len : rem_q - ADDR_W'(1);
            end
         end
         ST_RELEASE: begin
            abort_d = abort_q || stop;
            if (!done_12) begin
               state_d = abort_d ? ST_IDLE : ST_ISSUE;
               flush   = abort_d;
               busy_d  = !abort_d;
               abort_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clock_12 or negedge reset_12_n) begin
      if (!reset_12_n) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         abort_q <= abort_d;
      end
   end
endmodule

// File: tb/tb_sdram_sample_fetcher.sv
// tb_sdram_sample_fetcher: directed bench with a negedge-driven reader model and a sample scoreboard.
module tb_sdram_sample_fetcher;
   import sdram_fetch_pkg::*;
   logic clock_12 = 1'b0, reset_12_n = 1'b0, start = 1'b0, stop = 1'b0;
   logic done_12 = 1'b0, sample_ready = 1'b0, request_12, busy, sample_valid;
   addr_t base_addr = '0, length = '0, address_12;
   sample_t readdata_12 = '0, sample_data, rd_val = '0;
`ifdef SDRAM_SAMPLE_FETCHER_LOOP_EN
   logic loop_en = 1'b0;
`endif
   int checks = 0, errors = 0, pops = 0, reqs = 0;
   sample_t exp_q[$], got_q[$];
   addr_t addr_log[$];
   logic expect_push = 1'b1;
   always #5 clock_12 = ~clock_12;
   sdram_sample_fetcher dut (
      .clock_12    (clock_12),
      .reset_12_n  (reset_12_n),
      .start       (start),
      .stop        (stop),
      .base_addr   (base_addr),
      .length      (length),
`ifdef SDRAM_SAMPLE_FETCHER_LOOP_EN
      .loop_en     (loop_en),
`endif
      .busy        (busy),
      .address_12  (address_12),
      .request_12  (request_12),
      .done_12     (done_12),
      .readdata_12 (readdata_12),
      .sample_data (sample_data),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready)
   );
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock_12);
         #1;
      end
   endtask
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
      end
   endtask
   task automatic pulse_start(input addr_t b, input addr_t l);
      base_addr = b;
      length    = l;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask
   task automatic wait_idle(input string name, input int lim);
      int n = 0;
      while (busy && n < lim) begin
         tick();
         n++;
      end
      chk(name, busy, 0);
   endtask
   // reader: two cycles after a request, done high for three cycles with the next counter value
   initial begin
      forever begin
         @(negedge clock_12);
         if (request_12) begin
            reqs++;
            addr_log.push_back(address_12);
            repeat (2) @(negedge clock_12);
            rd_val      = rd_val + 16'd1;
            readdata_12 = rd_val;
            done_12     = 1'b1;
            if (expect_push) exp_q.push_back(rd_val);
            repeat (3) @(negedge clock_12);
            done_12 = 1'b0;
         end
      end
   end
   // per-cycle protocol rules and stream scoreboard
   initial begin
      logic req_prev = 1'b0;
      addr_t addr_prev = '0;
      sample_t want;
      forever begin
         @(posedge clock_12);
         #3;
         if (reset_12_n) begin
            if (done_12) begin
               checks++;
               if (request_12) begin
                  errors++;
                  $display("FAIL req_vs_done: request_12=1 while done_12=1, required 0");
               end
            end
            if (request_12 && req_prev) begin
               checks++;
               if (address_12 !== addr_prev) begin
                  errors++;
                  $display("FAIL addr_stable: got 0x%0h, required 0x%0h", address_12, addr_prev);
               end
            end
            if (sample_valid && sample_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL stream: got 0x%0h, required no sample", sample_data);
               end else begin
                  want = exp_q.pop_front();
                  if (sample_data !== want) begin
                     errors++;
                     $display("FAIL stream: got 0x%0h, required 0x%0h", sample_data, want);
                  end
               end
               got_q.push_back(sample_data);
               pops++;
            end
         end
         req_prev  = request_12;
         addr_prev = address_12;
      end
   end
   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end
   initial begin
      int n, r0, p0;
      logic busy_drop;
      tick(2);
      chk("rst_busy", busy, 0);
      chk("rst_req", request_12, 0);
      chk("rst_addr", address_12, 0);
      chk("rst_valid", sample_valid, 0);
      chk("rst_data", sample_data, 0);
      reset_12_n = 1'b1;
      tick();
      // single run
      sample_ready = 1'b1;
      addr_log.delete();
      got_q.delete();
      rd_val = 16'hA000;
      pulse_start(26'h100, 26'd3);
      chk("lat_req", request_12, 1);
      chk("lat_addr", address_12, 32'h100);
      wait_idle("single_idle", 100);
      chk("single_nreq", addr_log.size(), 3);
      for (int i = 0; i < 3; i++) chk($sformatf("single_addr%0d", i), addr_log[i], 32'h100 + i);
      chk("single_npop", got_q.size(), 3);
      for (int i = 0; i < 3; i++) chk($sformatf("single_data%0d", i), got_q[i], 32'hA001 + i);
      // stop in IDLE flushes buffered samples
      sample_ready = 1'b0;
      pulse_start(26'h200, 26'd2);
      wait_idle("flush_idle", 100);
      chk("flush_valid_before", sample_valid, 1);
      stop = 1'b1;
      exp_q.delete();
      tick();
      stop = 1'b0;
      chk("flush_valid_after", sample_valid, 0);
      // backpressure
      r0 = reqs;
      p0 = pops;
      pulse_start(26'h400, 26'd12);
      tick(150);
      chk("bp_nreq", reqs - r0, 8);
      chk("bp_req_low", request_12, 0);
      chk("bp_busy", busy, 1);
      sample_ready = 1'b1;
      wait_idle("bp_idle", 400);
      tick(3);
      chk("bp_total_req", reqs - r0, 12);
      chk("bp_total_pop", pops - p0, 12);
      chk("bp_exp_empty", exp_q.size(), 0);
      // empty run
      r0 = reqs;
      pulse_start(26'h300, 26'd0);
      chk("empty_busy_hi", busy, 1);
      tick();
      chk("empty_busy_lo", busy, 0);
      tick(20);
      chk("empty_nreq", reqs - r0, 0);
      // abort in WAIT_DONE
      r0 = reqs;
      pulse_start(26'h40, 26'd4);
      chk("abort_req", request_12, 1);
      expect_push = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n = 0;
      while (!done_12 && n < 20) begin
         tick();
         n++;
      end
      chk("abort_done_seen", done_12, 1);
      chk("abort_req_drop", request_12, 0);
      busy_drop = 1'b0;
      n = 0;
      while (done_12 && n < 20) begin
         if (!busy) busy_drop = 1'b1;
         tick();
         n++;
      end
      chk("abort_busy_during_done", busy_drop, 0);
      chk("abort_done_fell", done_12, 0);
      chk("abort_busy_lo", busy, 0);
      chk("abort_valid", sample_valid, 0);
      tick(20);
      chk("abort_nreq", reqs - r0, 1);
      expect_push = 1'b1;
      // address wrap
      addr_log.delete();
      pulse_start(26'h3FFFFFF, 26'd2);
      wait_idle("wrap_idle", 100);
      chk("wrap_nreq", addr_log.size(), 2);
      chk("wrap_addr0", addr_log[0], 32'h3FFFFFF);
      chk("wrap_addr1", addr_log[1], 32'h0);
`ifdef SDRAM_SAMPLE_FETCHER_LOOP_EN
      addr_log.delete();
      loop_en = 1'b1;
      pulse_start(26'h20, 26'd2);
      loop_en = 1'b0;
      busy_drop = 1'b0;
      n = 0;
      while (addr_log.size() < 5 && n < 100) begin
         tick();
         n++;
         if (!busy) busy_drop = 1'b1;
      end
      expect_push = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("loop_busy", busy_drop, 0);
      chk("loop_nreq", addr_log.size(), 5);
      for (int i = 0; i < 5; i++) chk($sformatf("loop_addr%0d", i), addr_log[i], (i % 2) ? 32'h21 : 32'h20);
      wait_idle("loop_idle", 100);
      tick(10);
      expect_push = 1'b1;
      exp_q.delete();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
